// File: rtl/fir_param_pipe_if.sv
// -----------------------------------------------------------------------------
// fir_param_pipe_if
//
// Sample stream and coefficient load bundle for fir_param_pipe.
//
// Signals:
//   in_valid   x_in carries a sample this cycle
//   x_in       input sample, signed DW bits
//   coef_we    write coef_data into the shadow coefficient bank
//   coef_addr  tap index for the write, clog2(TAPS) bits
//   coef_data  coefficient value, signed CW bits
//   coef_swap  one-cycle pulse: shadow bank becomes active
//   out_valid  y_out carries a filtered sample
//   y_out      filtered, rounded, saturated output, signed DW bits
//
// Modports:
//   master  sample source / coefficient loader (drives inputs, sees outputs)
//   slave   the filter itself
// -----------------------------------------------------------------------------
interface fir_param_pipe_if #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned TAPS = 16
);
    localparam int unsigned ADW = $clog2(TAPS);

    logic                  in_valid;
    logic signed [DW-1:0]  x_in;
    logic                  coef_we;
    logic [ADW-1:0]        coef_addr;
    logic signed [CW-1:0]  coef_data;
    logic                  coef_swap;
    logic                  out_valid;
    logic signed [DW-1:0]  y_out;

    modport master (
        output in_valid,
        output x_in,
        output coef_we,
        output coef_addr,
        output coef_data,
        output coef_swap,
        input  out_valid,
        input  y_out
    );

    modport slave (
        input  in_valid,
        input  x_in,
        input  coef_we,
        input  coef_addr,
        input  coef_data,
        input  coef_swap,
        output out_valid,
        output y_out
    );
endinterface

// File: rtl/fir_param_pipe.sv
// -----------------------------------------------------------------------------
// fir_param_pipe
//
// Parametrised, fully pipelined streaming FIR filter with double-buffered,
// runtime-loadable coefficients. Latency is fixed at 2 + clog2(TAPS) cycles
// from sample acceptance to out_valid; one sample per cycle, no backpressure.
//
// Parameters:
//   DW    sample / output width (signed)
//   CW    coefficient width (signed)
//   TAPS  number of taps, >= 2
//   FRAC  fractional bits removed at the output, 1 <= FRAC
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fir_param_pipe_if.slave: sample stream in, coefficient load,
//          filtered stream out
//
// Pipeline:
//   history shift (accept edge) -> products -> clog2(TAPS) adder levels ->
//   round / saturate / output register
// -----------------------------------------------------------------------------
module fir_param_pipe #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned TAPS = 16,
    parameter int unsigned FRAC = 15
) (
    input logic             clk,
    input logic             rst_n,
    fir_param_pipe_if.slave bus
);
    localparam int unsigned LOG = $clog2(TAPS);
    localparam int unsigned NP  = 1 << LOG;     // leaves padded to a power of two
    localparam int unsigned PW  = DW + CW;      // full product width
    localparam int unsigned AW  = PW + LOG;     // accumulator width, cannot overflow

    localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);

    // -------------------------------------------------------------------------
    // Sample history: shifts only on accepted samples
    // -------------------------------------------------------------------------
    logic signed [DW-1:0] x_hist_q [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_hist_q[i] <= '0;
            end
        end else if (bus.in_valid) begin
            x_hist_q[0] <= bus.x_in;
            for (int i = 1; i < TAPS; i++) begin
                x_hist_q[i] <= x_hist_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Coefficient banks. sel_q = 0 -> A active, B shadow; sel_q = 1 -> swapped.
    // A write in the same cycle as a swap lands in the pre-swap shadow, which
    // is the bank that becomes active after the edge.
    // -------------------------------------------------------------------------
    logic signed [CW-1:0] bank_a_q [TAPS];
    logic signed [CW-1:0] bank_b_q [TAPS];
    logic                 sel_q;
    logic                 addr_ok;
    logic signed [CW-1:0] coef_act [TAPS];

    assign addr_ok = {{(32-LOG){1'b0}}, bus.coef_addr} < TAPS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                bank_a_q[i] <= '0;
                bank_b_q[i] <= '0;
            end
            sel_q <= 1'b0;
        end else begin
            if (bus.coef_we && addr_ok) begin
                if (sel_q) begin
                    bank_a_q[bus.coef_addr] <= bus.coef_data;
                end else begin
                    bank_b_q[bus.coef_addr] <= bus.coef_data;
                end
            end
            if (bus.coef_swap) begin
                sel_q <= ~sel_q;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            coef_act[i] = sel_q ? bank_b_q[i] : bank_a_q[i];
        end
    end

    // -------------------------------------------------------------------------
    // Products: every tap of one sample is formed in the same cycle from the
    // same bank, so a swap can never split a sample across banks.
    // -------------------------------------------------------------------------
    logic signed [PW-1:0] prod_q [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= PW'(x_hist_q[i]) * PW'(coef_act[i]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Adder tree in heap layout: node k has children 2k and 2k+1. Leaves live
    // at NP..2NP-1 (products, zero-padded), registered sums at 1..NP-1, root
    // at 1. Each level is one register stage, so the root lags the products
    // by exactly LOG cycles. Index 0 is unused.
    // -------------------------------------------------------------------------
    logic signed [AW-1:0] node  [2*NP];
    logic signed [AW-1:0] sum_q [NP];

    always_comb begin
        node = '{default: '0};
        for (int k = 0; k < NP; k++) begin
            node[k] = sum_q[k];
        end
        for (int i = 0; i < TAPS; i++) begin
            node[NP+i] = AW'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NP; k++) begin
                sum_q[k] <= '0;
            end
        end else begin
            sum_q[0] <= '0;
            for (int k = 1; k < NP; k++) begin
                sum_q[k] <= node[2*k] + node[2*k+1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Valid token chain. Bit 0 marks the history stage, bit 1 the product
    // stage, bit LOG+1 the tree root.
    // -------------------------------------------------------------------------
    logic [LOG+1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LOG:0], bus.in_valid};
        end
    end

    // -------------------------------------------------------------------------
    // Round half up, arithmetic shift, saturate to DW bits.
    // -------------------------------------------------------------------------
    logic signed [AW-1:0] rnd_sum;
    logic signed [AW-1:0] shifted;
    logic signed [DW-1:0] sat;

    always_comb begin
        rnd_sum = sum_q[1] + RND;
        shifted = rnd_sum >>> FRAC;
        // In range when every bit above the DW-bit sign position matches it
        if (shifted[AW-1:DW-1] == {(AW-DW+1){shifted[AW-1]}}) begin
            sat = shifted[DW-1:0];
        end else if (shifted[AW-1]) begin
            sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DW-1){1'b1}}};
        end
    end

    // -------------------------------------------------------------------------
    // Output register: y holds its last value between valid samples.
    // -------------------------------------------------------------------------
    logic                 out_valid_q;
    logic signed [DW-1:0] y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            out_valid_q <= vld_q[LOG+1];
            if (vld_q[LOG+1]) begin
                y_q <= sat;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;

endmodule

// File: tb/tb_fir_param_pipe.sv
// -----------------------------------------------------------------------------
// tb_fir_param_pipe
//
// Self-checking bench for fir_param_pipe. A behavioural convolution model
// predicts each output when a sample is driven and queues it with the cycle it
// is due; a negedge monitor pops and compares whenever out_valid is seen, and
// checks that y_out holds otherwise.
// -----------------------------------------------------------------------------
module tb_fir_param_pipe;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 16;
    localparam int unsigned TAPS = 16;
    localparam int unsigned FRAC = 15;
    localparam int unsigned LAT  = 6;
    localparam int unsigned ADW  = $clog2(TAPS);

    typedef struct {
        longint y;
        int     due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int     cyc      = 0;
    int     n_checks = 0;
    int     n_fails  = 0;
    exp_t   sb[$];
    longint got[$];
    longint last_y   = 0;

    longint m_bank [2][TAPS];
    int     m_sel;
    longint m_hist [TAPS];

    longint imp_c [TAPS] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                             512, 256, 128, 64, 32, 16, 8, 4};
    longint imp_y [TAPS] = '{256, 512, 1024, 2048, 4096, 2048, 1024, 512,
                             256, 128, 64, 32, 16, 8, 4, 2};
    longint rnd_y [3]    = '{1, 0, -1};
    longint cset  [TAPS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_param_pipe_if #(.DW(DW), .CW(CW), .TAPS(TAPS)) bus ();

    fir_param_pipe #(
        .DW   (DW),
        .CW   (CW),
        .TAPS (TAPS),
        .FRAC (FRAC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic longint model_y();
        longint acc = 0;
        longint r;
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -hi - 1;
        for (int i = 0; i < TAPS; i++) begin
            acc += m_hist[i] * m_bank[m_sel][i];
        end
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic reset_model();
        sb.delete();
        got.delete();
        m_sel  = 0;
        last_y = 0;
        for (int i = 0; i < TAPS; i++) begin
            m_bank[0][i] = 0;
            m_bank[1][i] = 0;
            m_hist[i]    = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.coef_swap = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, mirror the edge in the model.
    task automatic cycle(input bit v, input longint x, input bit we, input int addr,
                         input longint data, input bit swap);
        bus.in_valid  = v;
        bus.x_in      = DW'(x);
        bus.coef_we   = we;
        bus.coef_addr = ADW'(addr);
        bus.coef_data = CW'(data);
        bus.coef_swap = swap;
        @(posedge clk);
        #1;
        if (we && addr < TAPS) m_bank[1-m_sel][addr] = data;
        if (swap) m_sel = 1 - m_sel;
        if (v) begin
            for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = x;
            sb.push_back('{y: model_y(), due: cyc + LAT});
        end
        idle_inputs();
    endtask

    task automatic load_shadow(input longint c [TAPS]);
        for (int i = 0; i < TAPS; i++) cycle(1'b0, 0, 1'b1, i, c[i], 1'b0);
    endtask

    task automatic swap_banks();
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 4 * LAT + 8) begin
            cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    function automatic longint got_at(input int k);
        return (k < got.size()) ? got[k] : -999999;
    endfunction

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_cycle", cyc, e.due);
                    check("y_out", bus.y_out, e.y);
                    got.push_back(bus.y_out);
                    last_y = bus.y_out;
                end
            end else begin
                check("y_hold", bus.y_out, last_y);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

    initial begin : stim
        idle_inputs();
        reset_model();
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y_out", bus.y_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse response
        load_shadow(imp_c);
        swap_banks();
        got.delete();
        for (int k = 0; k < TAPS; k++) cycle(1'b1, (k == 0) ? 16384 : 0, 1'b0, 0, 0, 1'b0);
        drain();
        check("impulse_count", got.size(), TAPS);
        for (int k = 0; k < TAPS; k++) check("impulse_y", got_at(k), imp_y[k]);

        // Same impulse with gaps between samples
        got.delete();
        for (int k = 0; k < TAPS; k++) begin
            cycle(1'b1, (k == 0) ? 16384 : 0, 1'b0, 0, 0, 1'b0);
            cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
        end
        drain();
        for (int k = 0; k < TAPS; k++) check("gapped_y", got_at(k), imp_y[k]);

        // Rounding
        for (int i = 0; i < TAPS; i++) cset[i] = (i == 0) ? 1 : 0;
        load_shadow(cset);
        swap_banks();
        got.delete();
        cycle(1'b1, 16384, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, -16384, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, -16385, 1'b0, 0, 0, 1'b0);
        drain();
        for (int k = 0; k < 3; k++) check("round_y", got_at(k), rnd_y[k]);

        // Saturation in both directions
        for (int i = 0; i < TAPS; i++) cset[i] = 32767;
        load_shadow(cset);
        swap_banks();
        got.delete();
        for (int k = 0; k < 2 * TAPS; k++) cycle(1'b1, (k < TAPS) ? 32767 : -32768, 1'b0, 0, 0, 1'b0);
        drain();
        check("sat_pos", got_at(TAPS - 1), 32767);
        check("sat_neg", got_at(2 * TAPS - 1), -32768);

        // Bank swap mid-stream: swap on the edge that accepts sample 4
        for (int i = 0; i < TAPS; i++) cset[i] = (i == 0) ? 16384 : 0;
        load_shadow(cset);
        swap_banks();
        for (int i = 0; i < TAPS; i++) cset[i] = (i == 0) ? 8192 : 0;
        load_shadow(cset);
        got.delete();
        for (int k = 0; k < 10; k++) cycle(1'b1, 32767, 1'b0, 0, 0, k == 4);
        drain();
        for (int k = 0; k < 10; k++) check("swap_y", got_at(k), (k < 4) ? 16384 : 8192);

        // Write and swap on the same edge: write lands in the bank going active
        got.delete();
        cycle(1'b0, 0, 1'b1, 0, 4096, 1'b1);
        cycle(1'b1, 32767, 1'b0, 0, 0, 1'b0);
        drain();
        check("we_swap_y", got_at(0), 4096);

        // Reset with three samples in flight
        for (int k = 0; k < 3; k++) cycle(1'b1, 32767, 1'b0, 0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_y_out", bus.y_out, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        swap_banks();
        for (int k = 0; k < TAPS; k++) cycle(1'b1, (k == 0) ? 16384 : 0, 1'b0, 0, 0, 1'b0);
        drain();
        check("post_rst_count", got.size(), TAPS);
        for (int k = 0; k < TAPS; k++) check("post_rst_y", got_at(k), 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
